cp0_irq_ctl: RTL and testbench



---
 rtl/cp0_irq_ctl_pkg.sv | 25 ++
 rtl/cp0_irq_fsm.sv | 47 ++++
 rtl/cp0_irq_ctl.sv | 120 ++++++++++++
 tb/tb_cp0_irq_ctl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_irq_ctl_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and FSM encodings.
// Used by cp0_irq_fsm and cp0_irq_ctl (optional macro CP0_EXC_EN lives in the top).
package cp0_defs;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'h0,
        ST_REQ    = 2'h1,
        ST_IN_ISR = 2'h2
    } cp0_state_e;

endpackage

// File: rtl/cp0_irq_fsm.sv
// Interrupt request FSM: pending detection, IDLE/REQ/IN_ISR sequencing and IRQ generation.
// force_i lets the top raise IRQ immediately for synchronous exceptions.
module cp0_irq_fsm
    import cp0_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] ip_i,
    input  logic [5:0] im_i,
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic       isr_entering_i,
    input  logic       isr_leaving_i,
    input  logic       force_i,
    output logic       irq_o
);

    cp0_state_e state_q, state_d;
    logic       pending;

    assign pending = (|(ip_i & im_i)) & ie_i & ~exl_i;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (isr_entering_i) begin
            state_d = ST_IN_ISR;
        end else if (isr_leaving_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (pending)  state_d = ST_REQ;
                ST_REQ:    if (!pending) state_d = ST_IDLE;
                ST_IN_ISR: state_d = ST_IN_ISR;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    assign irq_o = (state_q == ST_REQ) | force_i;

endmodule

// File: rtl/cp0_irq_ctl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId registers, mfc0/mtc0 port and IRQ handshake.
// Optional macro CP0_EXC_EN adds exc_req/exc_code and the Cause.ExcCode field.
module cp0_irq_ctl
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID       = 32'h4D49_5053,
    parameter logic [31:0] ISR_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  HWInt,
    output logic        IRQ,
    input  logic        ISR_entering,
    input  logic        ISR_leaving,
    input  logic [31:0] victim_pc,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [31:0] EPC,
`ifdef CP0_EXC_EN
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
`endif
    output logic [31:0] isr_vector
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  exc_rd;
    logic        irq_force;
    logic        wr_sr, wr_epc;

    assign wr_sr  = cp0_we && (cp0_addr == ADDR_SR);
    assign wr_epc = cp0_we && (cp0_addr == ADDR_EPC);

`ifdef CP0_EXC_EN
    logic [4:0] exc_code_q;

    assign irq_force = exc_req & ~exl_q;
    assign exc_rd    = exc_code_q;

    // Entry taken while an exception is forcing IRQ records its code; a hardware entry records 0.
    always_ff @(posedge clk) begin
        if (rst)               exc_code_q <= '0;
        else if (ISR_entering) exc_code_q <= irq_force ? exc_code : 5'd0;
    end
`else
    assign irq_force = 1'b0;
    assign exc_rd    = 5'd0;
`endif

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        epc_d = epc_q;
        if (wr_sr) begin
            im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
            exl_d = cp0_wdata[SR_EXL];
            ie_d  = cp0_wdata[SR_IE];
        end
        if (wr_epc) epc_d = cp0_wdata & 32'hFFFF_FFFC;
        // ISR entry outranks both eret and any mtc0 in the same cycle.
        if (ISR_entering) begin
            exl_d = 1'b1;
            epc_d = victim_pc & 32'hFFFF_FFFC;
        end else if (ISR_leaving) begin
            exl_d = 1'b0;
        end
    end

    // NOTE: every state register here is reset; the register file is flops, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            ip_q  <= HWInt;
            epc_q <= epc_d;
        end
    end

    cp0_irq_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .ip_i           (ip_q),
        .im_i           (im_q),
        .ie_i           (ie_q),
        .exl_i          (exl_q),
        .isr_entering_i (ISR_entering),
        .isr_leaving_i  (ISR_leaving),
        .force_i        (irq_force),
        .irq_o          (IRQ)
    );

    always_comb begin
        cp0_rdata = 32'h0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'h0, im_q, 8'h0, exl_q, ie_q};
            ADDR_CAUSE: cp0_rdata = {16'h0, ip_q, 3'b0, exc_rd, 2'b0};
            ADDR_EPC:   cp0_rdata = epc_q;
            ADDR_PRID:  cp0_rdata = PRID;
            default:    cp0_rdata = 32'h0;
        endcase
    end

    assign EPC        = epc_q;
    assign isr_vector = ISR_VECTOR;

endmodule

// File: tb/tb_cp0_irq_ctl.sv
// Scoreboard bench for cp0_irq_ctl: directed stimulus pushes expectations, a negedge monitor checks.
// Build with CP0_EXC_EN defined to also cover the exception path.
module tb_cp0_irq_ctl;

    typedef enum logic [1:0] {K_IRQ, K_EPC, K_RD, K_VEC} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  HWInt;
    logic        IRQ;
    logic        ISR_entering;
    logic        ISR_leaving;
    logic [31:0] victim_pc;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] EPC;
    logic [31:0] isr_vector;
`ifdef CP0_EXC_EN
    logic        exc_req;
    logic [4:0]  exc_code;
`endif

    sb_entry_t sb_q[$];
    sb_entry_t ent;
    logic [31:0] act;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cp0_irq_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .HWInt        (HWInt),
        .IRQ          (IRQ),
        .ISR_entering (ISR_entering),
        .ISR_leaving  (ISR_leaving),
        .victim_pc    (victim_pc),
        .cp0_addr     (cp0_addr),
        .cp0_we       (cp0_we),
        .cp0_wdata    (cp0_wdata),
        .cp0_rdata    (cp0_rdata),
        .EPC          (EPC),
`ifdef CP0_EXC_EN
        .exc_req      (exc_req),
        .exc_code     (exc_code),
`endif
        .isr_vector   (isr_vector)
    );

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            case (ent.kind)
                K_IRQ:   act = {31'b0, IRQ};
                K_EPC:   act = EPC;
                K_VEC:   act = isr_vector;
                default: act = cp0_rdata;
            endcase
            tests++;
            if (act !== ent.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", ent.name, act, ent.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input kind_e k, input logic [31:0] e, input string n);
        sb_entry_t x;
        x.kind = k;
        x.exp  = e;
        x.name = n;
        sb_q.push_back(x);
    endtask

    task automatic exp_irq(input logic v, input string n);
        push(K_IRQ, {31'b0, v}, n);
    endtask

    // Read check occupies cp0_addr for the current cycle, then advances one edge.
    task automatic exp_rd(input logic [4:0] a, input logic [31:0] e, input string n);
        cp0_addr = a;
        push(K_RD, e, n);
        tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_addr  = a;
        cp0_wdata = d;
        cp0_we    = 1'b1;
        tick();
        cp0_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; HWInt = '0; ISR_entering = 0; ISR_leaving = 0;
        victim_pc = '0; cp0_addr = '0; cp0_we = 0; cp0_wdata = '0;
`ifdef CP0_EXC_EN
        exc_req = 0; exc_code = '0;
`endif
        tick(); tick();
        rst = 1'b0;

        // Reset state
        exp_irq(0, "reset_irq");
        push(K_EPC, 32'h0, "reset_epc");
        push(K_VEC, 32'h0000_4180, "isr_vector");
        exp_rd(5'd12, 32'h0, "reset_sr");
        exp_rd(5'd15, 32'h4D49_5053, "prid");
        exp_rd(5'd13, 32'h0, "reset_cause");

        // Basic interrupt: HWInt before edge N, IRQ after edge N+1
        mtc0(5'd12, 32'h0000_0401);
        exp_rd(5'd12, 32'h0000_0401, "sr_written");
        HWInt = 6'b000001;
        tick();                                  // edge N
        exp_irq(0, "irq_after_N");
        exp_rd(5'd13, 32'h0000_0400, "cause_ip0"); // edge N+1
        exp_irq(1, "irq_after_N1");
        ISR_entering = 1; victim_pc = 32'h0000_3010;
        tick();
        ISR_entering = 0;
        exp_irq(0, "irq_in_isr");
        push(K_EPC, 32'h0000_3010, "epc_entry");
        exp_rd(5'd12, 32'h0000_0403, "sr_exl_set");
        exp_irq(0, "irq_masked_by_exl");
        tick();

        // Eret with source still high, then re-raise
        ISR_leaving = 1;
        tick();
        ISR_leaving = 0;
        exp_irq(0, "irq_after_eret");
        push(K_EPC, 32'h0000_3010, "epc_held");
        exp_rd(5'd12, 32'h0000_0401, "sr_exl_clr");
        exp_irq(1, "irq_reraised");

        // Withdrawn request: IRQ drops one cycle after IP clears
        HWInt = 6'b0;
        tick();
        exp_irq(1, "irq_withdraw_lag");
        tick();
        exp_irq(0, "irq_withdrawn");

        // Masked source
        HWInt = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            exp_irq(0, "irq_masked");
            tick();
        end
        exp_rd(5'd13, 32'h0000_0800, "cause_ip1");
        HWInt = 6'b0;

        // Collision: mtc0 EPC vs entry from IDLE
        cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234; cp0_we = 1;
        ISR_entering = 1; victim_pc = 32'h0000_2003;
        tick();
        cp0_we = 0; ISR_entering = 0;
        push(K_EPC, 32'h0000_2000, "epc_collision");
        exp_rd(5'd12, 32'h0000_0403, "sr_idle_entry");

        // Eret with simultaneous SR write: IM/IE kept, EXL forced 0
        cp0_addr = 5'd12; cp0_wdata = 32'h0000_0C03; cp0_we = 1; ISR_leaving = 1;
        tick();
        cp0_we = 0; ISR_leaving = 0;
        exp_rd(5'd12, 32'h0000_0C01, "sr_leave_write");

        // Collision: mtc0 SR <- 0 with entry
        cp0_addr = 5'd12; cp0_wdata = 32'h0; cp0_we = 1;
        ISR_entering = 1; victim_pc = 32'h0000_4444;
        tick();
        cp0_we = 0; ISR_entering = 0;
        exp_rd(5'd12, 32'h0000_0002, "sr_write_entry");

        // Entering and leaving together: entering wins
        ISR_entering = 1; ISR_leaving = 1; victim_pc = 32'h0000_500B;
        tick();
        ISR_entering = 0; ISR_leaving = 0;
        push(K_EPC, 32'h0000_5008, "epc_enter_leave");
        exp_rd(5'd12, 32'h0000_0002, "sr_enter_leave");
        ISR_leaving = 1;
        tick();
        ISR_leaving = 0;
        exp_rd(5'd12, 32'h0, "sr_after_leave");

        // Ignored writes, field masking, plain EPC write
        mtc0(5'd13, 32'hFFFF_FFFF);
        exp_rd(5'd13, 32'h0, "cause_ro");
        mtc0(5'd15, 32'h0);
        exp_rd(5'd15, 32'h4D49_5053, "prid_ro");
        exp_rd(5'd3, 32'h0, "unmapped");
        mtc0(5'd14, 32'hABCD_0127);
        push(K_EPC, 32'hABCD_0124, "epc_mtc0");
        mtc0(5'd12, 32'hFFFF_FFFF);
        exp_rd(5'd12, 32'h0000_FC03, "sr_mask");
        mtc0(5'd12, 32'h0);

`ifdef CP0_EXC_EN
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; exc_req = 1; exc_code = 5'd12;
        exp_irq(1, "exc_irq_comb");
        ISR_entering = 1; victim_pc = 32'h0000_6000;
        tick();
        ISR_entering = 0;
        exp_rd(5'd13, 32'h0000_0430, "cause_exccode");
        exp_irq(0, "exc_ignored_exl");
        exc_req = 0;
        ISR_leaving = 1;
        tick();
        ISR_leaving = 0;
        tick();
        exp_irq(1, "hw_req_after_exc");
        ISR_entering = 1;
        tick();
        ISR_entering = 0;
        exp_rd(5'd13, 32'h0000_0400, "cause_hw_exc0");
`endif

        tick(); tick();
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
